multi_width_fifo: RTL

Multi-lane FIFO with data storage. It accepts up to PUSH_WIDTH entries and delivers up to POP_WIDTH entries per cycle, and wraps the multi-width queue pointer controller with entry RAM, lane compaction and flow control. It sits between a wide producer (e.g. rename/dispatch group) and a narrower or equal-width consumer, and serves as the standard buffered instance of the pointer primitive.

---
 rtl/multi_width_fifo_pkg.sv | 23 ++
 rtl/multi_width_fifo_qptr.sv | 39 +++
 rtl/multi_width_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/multi_width_fifo_pkg.sv
// Shared index/count width helpers and modular pointer arithmetic for the
// multi-width queue family; SIZE need not be a power of two.
package multi_width_fifo_pkg;

  // Index path: addresses 0..SIZE-1 (at least one bit for SIZE=1).
  function automatic int index_path_bits(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Count path: holds 0..SIZE inclusive.
  function automatic int count_path_bits(input int size);
    return $clog2(size) + 1;
  endfunction

  // Operands are always < size and <= size respectively, so one subtract wraps.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned size);
    int unsigned s;
    s = a + b;
    return (s >= size) ? s - size : s;
  endfunction

endpackage

// File: rtl/multi_width_fifo_qptr.sv
// Head/tail/count pointer controller for a queue that moves several entries
// per cycle in each direction.
module multi_width_fifo_qptr
  import multi_width_fifo_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int IW   = 4,
  parameter int CW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [CW-1:0] push_count,
  input  logic          pop,
  input  logic [CW-1:0] pop_count,
  output logic [IW-1:0] head,
  output logic [IW-1:0] tail,
  output logic [CW-1:0] count
);

  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_amt;

  assign push_amt = push ? push_count : '0;
  assign pop_amt  = pop  ? pop_count  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= IW'(mod_add(32'(tail), 32'(push_count), SIZE));
      if (pop)  head <= IW'(mod_add(32'(head), 32'(pop_count), SIZE));
      count <= count + push_amt - pop_amt;
    end
  end

endmodule

// File: rtl/multi_width_fifo.sv
// Buffered multi-lane FIFO: compacts up to PUSH_WIDTH valid lanes per cycle
// into entry storage and presents up to POP_WIDTH entries from the head.
module multi_width_fifo
  import multi_width_fifo_pkg::*;
#(
  parameter int SIZE        = 16,
  parameter int ENTRY_WIDTH = 32,
  parameter int PUSH_WIDTH  = 2,
  parameter int POP_WIDTH   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic [PUSH_WIDTH-1:0]                     pushValid,
  input  logic [PUSH_WIDTH-1:0][ENTRY_WIDTH-1:0]    pushData,
  output logic                                      pushReady,
  input  logic [$clog2(POP_WIDTH):0]                popCount,
  output logic [POP_WIDTH-1:0]                      popValid,
  output logic [POP_WIDTH-1:0][ENTRY_WIDTH-1:0]     popData,
  output logic [$clog2(SIZE):0]                     count,
  output logic                                      full,
  output logic                                      empty
);

  localparam int IW = index_path_bits(SIZE);
  localparam int CW = count_path_bits(SIZE);

  logic [ENTRY_WIDTH-1:0] mem [SIZE];

  logic [IW-1:0]           head;
  logic [IW-1:0]           tail;
  logic [CW-1:0]           prefix [PUSH_WIDTH];
  logic [CW-1:0]           push_count;
  logic [CW-1:0]           pop_eff;
  logic [IW-1:0]           waddr [PUSH_WIDTH];
  logic [PUSH_WIDTH-1:0]   we;
  logic                    accepted_push;

  // Ready depends only on registered count; a same-cycle pop never helps.
  assign pushReady     = (CW'(SIZE) - count) >= CW'(PUSH_WIDTH);
  assign accepted_push = pushReady && (|pushValid);
  assign full          = (count == CW'(SIZE));
  assign empty         = (count == '0);

  always_comb begin
    push_count = '0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      prefix[k] = push_count;
      if (pushValid[k]) push_count = push_count + CW'(1);
    end
  end

  always_comb begin
    we = '0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      waddr[k] = IW'(mod_add(32'(tail), 32'(prefix[k]), SIZE));
      we[k]    = accepted_push && pushValid[k] && !flush && !rst;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      if (we[k]) mem[waddr[k]] <= pushData[k];
    end
  end

  // Over-requested pops are clamped so the pointers never pass the tail.
  always_comb begin
    if (32'(popCount) > 32'(count)) pop_eff = count;
    else                            pop_eff = CW'(popCount);
  end

  always_comb begin
    popValid = '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      popValid[i] = (32'(i) < 32'(count));
      popData[i]  = mem[IW'(mod_add(32'(head), 32'(i), SIZE))];
    end
  end

  multi_width_fifo_qptr #(
    .SIZE (SIZE),
    .IW   (IW),
    .CW   (CW)
  ) u_qptr (
    .clk        (clk),
    .rst        (rst || flush),
    .push       (accepted_push),
    .push_count (push_count),
    .pop        (pop_eff != '0),
    .pop_count  (pop_eff),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

  a_pop_le_count: assert property (@(posedge clk) disable iff (rst || flush)
                                   32'(popCount) <= 32'(count));
  a_count_le_size: assert property (@(posedge clk) disable iff (rst)
                                    count <= CW'(SIZE));

endmodule
